// File: rtl/cache_sram_pkg.sv
// Shared constants and FSM state type for the cache SRAM port arbiter.
package cache_sram_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 128;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/cache_sram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. A one-bit pointer selects the winner
// when both requests are raised; after any grant it points at the other side.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 favours req[0], 1 favours req[1]
  logic ptr_q, ptr_d;

  // Grant selection and pointer advance
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) ptr_d = 1'b1;
    if (gnt[1]) ptr_d = 1'b0;
  end

  // Pointer register, reset favours req[0]
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_sram_arbiter.sv
// cache_sram_arbiter: shares one single-port cache SRAM macro between the
// lookup path (rq0) and the refill/writeback path (rq1). One access per
// cycle, active-low macro controls, read data returned one cycle later.
// Optional post-reset zero sweep of the array: define SRAM_CLEAR_EN.
module cache_sram_arbiter #(
  parameter int ADDR_W = cache_sram_pkg::ADDR_W,
  parameter int DATA_W = cache_sram_pkg::DATA_W,
  parameter int DEPTH  = cache_sram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic [DATA_W-1:0] rq0_wmask,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic [DATA_W-1:0] rq1_wmask,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic              rq0_rvalid,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  import cache_sram_pkg::*;

  // The sweep counter wraps exactly over the array only if DEPTH == 2**ADDR_W
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("cache_sram_arbiter: DEPTH must equal 2**ADDR_W");
  end

  state_e            state_q, state_d;
  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic [1:0]        arb_req, arb_gnt;
  logic [1:0]        rvalid_q, rvalid_d;

`ifdef SRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

  // Sweep sequencing: step through every entry, then hand over to RUN
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d   = ST_RUN;
      else                                 clr_idx_d = clr_idx_q + 1'b1;
    end
  end

  // State and sweep index; reset restarts the sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign clearing = (state_q == ST_CLEAR) && !rst;
  assign clr_addr = clr_idx_q;
  assign busy     = rst || (state_q == ST_CLEAR);
`else
  assign state_d  = ST_RUN;

  // Without the sweep the FSM never leaves RUN
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  // Requests only reach the arbiter in RUN and outside reset
  assign run     = (state_q == ST_RUN) && !rst;
  assign arb_req = {rq1_req, rq0_req} & {2{run}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  assign rq0_gnt = arb_gnt[0];
  assign rq1_gnt = arb_gnt[1];

  // Macro drive: sweep write, granted access, or idle (all controls inactive)
  always_comb begin
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_wmask = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (clearing) begin
      sram_cen   = 1'b0;
      sram_wen   = 1'b0;
      sram_wmask = '0;
      sram_addr  = clr_addr;
    end else if (arb_gnt[0]) begin
      sram_cen   = 1'b0;
      sram_wen   = ~rq0_we;
      sram_wmask = ~rq0_wmask;
      sram_addr  = rq0_addr;
      sram_wdata = rq0_wdata;
    end else if (arb_gnt[1]) begin
      sram_cen   = 1'b0;
      sram_wen   = ~rq1_we;
      sram_wmask = ~rq1_wmask;
      sram_addr  = rq1_addr;
      sram_wdata = rq1_wdata;
    end
  end

  assign rvalid_d = {arb_gnt[1] & ~rq1_we, arb_gnt[0] & ~rq0_we};

  // Read-return tracking: a granted read flags its owner in the next cycle
  always_ff @(posedge clk) begin
    if (rst) rvalid_q <= 2'b00;
    else     rvalid_q <= rvalid_d;
  end

  // Reset suppresses any return that was already in flight
  assign rq0_rvalid = rvalid_q[0] && !rst;
  assign rq1_rvalid = rvalid_q[1] && !rst;
  assign rq0_rdata  = sram_rdata;
  assign rq1_rdata  = sram_rdata;

endmodule
